// File: rtl/regwr_sel_pipe.sv
// -----------------------------------------------------------------------------
// regwr_sel_pipe
//
// Registered dual-port write-select decoder for the pipeline register file.
// Two write-back addresses (port A = primary WB, port B = secondary/late WB)
// are decoded into one-hot write-enable vectors and registered for exactly
// one cycle of latency. Supports stall (hold), flush (clear, wins over stall),
// hardwired-zero-register suppression and same-address arbitration in which
// port A wins and port B's write is dropped. Collisions are counted in a
// saturating counter.
//
// Parameters:
//   ADDR_W     address width; NUM_OUT = 2**ADDR_W decoded outputs (derived)
//   ZERO_GUARD 1 = address 0 never produces a write select
//   CNT_W      width of the saturating collision counter
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall        hold all registered outputs and the counter
//   flush        clear registered selects on the next edge (beats stall)
//   a_en/a_addr  port A write request and destination register
//   b_en/b_addr  port B write request and destination register
//   sel_a/sel_b  registered one-hot write selects
//   valid_a/_b   registered OR-reduction of the matching select
//   collide      registered: the sampled request had A and B effective to the
//                same address
//   collide_cnt  saturating number of collisions since reset
// -----------------------------------------------------------------------------
module regwr_sel_pipe #(
    parameter int  ADDR_W     = 5,
    parameter bit  ZERO_GUARD = 1'b1,
    parameter int  CNT_W      = 8,
    localparam int NUM_OUT    = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               a_en,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic               b_en,
    input  logic [ADDR_W-1:0]  b_addr,
    output logic [NUM_OUT-1:0] sel_a,
    output logic [NUM_OUT-1:0] sel_b,
    output logic               valid_a,
    output logic               valid_b,
    output logic               collide,
    output logic [CNT_W-1:0]   collide_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // A request is effective when enabled and not aimed at the hardwired
    // zero register (only when the guard is enabled).
    function automatic logic req_eff(input logic en, input logic [ADDR_W-1:0] addr);
        req_eff = en && !(ZERO_GUARD && (addr == ADDR_ZERO));
    endfunction

    logic               a_eff_s;
    logic               b_eff_s;
    logic               collide_s;
    logic               b_keep_s;
    logic [NUM_OUT-1:0] a_dec_s;
    logic [NUM_OUT-1:0] b_dec_s;
    logic [CNT_W-1:0]   cnt_next_s;

    logic [NUM_OUT-1:0] sel_a_r;
    logic [NUM_OUT-1:0] sel_b_r;
    logic               valid_a_r;
    logic               valid_b_r;
    logic               collide_r;
    logic [CNT_W-1:0]   collide_cnt_r;

    // Request qualification and same-address arbitration (A wins, B dropped).
    always_comb begin
        a_eff_s   = req_eff(a_en, a_addr);
        b_eff_s   = req_eff(b_en, b_addr);
        collide_s = a_eff_s && b_eff_s && (a_addr == b_addr);
        b_keep_s  = b_eff_s && !collide_s;
    end

    // One comparator per output line; each decoded vector is one-hot or zero.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_dec
        assign a_dec_s[i] = a_eff_s  && (a_addr == ADDR_W'(i));
        assign b_dec_s[i] = b_keep_s && (b_addr == ADDR_W'(i));
    end

    // Saturating increment of the collision counter; no wrap at full scale.
    always_comb begin
        cnt_next_s = collide_cnt_r;
        if (collide_s && (collide_cnt_r != CNT_MAX)) begin
            cnt_next_s = collide_cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = collide_cnt_r;
        end
    end

    // Output registers: flush clears selects (counter kept), stall holds all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_r       <= {NUM_OUT{1'b0}};
            sel_b_r       <= {NUM_OUT{1'b0}};
            valid_a_r     <= 1'b0;
            valid_b_r     <= 1'b0;
            collide_r     <= 1'b0;
            collide_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            sel_a_r       <= {NUM_OUT{1'b0}};
            sel_b_r       <= {NUM_OUT{1'b0}};
            valid_a_r     <= 1'b0;
            valid_b_r     <= 1'b0;
            collide_r     <= 1'b0;
            collide_cnt_r <= collide_cnt_r;
        end else if (stall) begin
            sel_a_r       <= sel_a_r;
            sel_b_r       <= sel_b_r;
            valid_a_r     <= valid_a_r;
            valid_b_r     <= valid_b_r;
            collide_r     <= collide_r;
            collide_cnt_r <= collide_cnt_r;
        end else begin
            sel_a_r       <= a_dec_s;
            sel_b_r       <= b_dec_s;
            valid_a_r     <= a_eff_s;
            valid_b_r     <= b_keep_s;
            collide_r     <= collide_s;
            collide_cnt_r <= cnt_next_s;
        end
    end

    assign sel_a       = sel_a_r;
    assign sel_b       = sel_b_r;
    assign valid_a     = valid_a_r;
    assign valid_b     = valid_b_r;
    assign collide     = collide_r;
    assign collide_cnt = collide_cnt_r;

endmodule

// File: tb/tb_regwr_sel_pipe.sv
// -----------------------------------------------------------------------------
// tb_regwr_sel_pipe
//
// Self-checking bench for regwr_sel_pipe. Three instances share clock, reset,
// stall and flush: the default configuration, a ZERO_GUARD=0 variant fed the
// same addresses, and an ADDR_W=3 variant with its own address inputs.
// Directed vectors with hand-computed expectations drive the default
// instance; hand-written sequences cover reset, zero-register handling,
// counter saturation and the exhaustive 3-bit address sweep.
// -----------------------------------------------------------------------------
module tb_regwr_sel_pipe;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        a_en;
    logic [4:0]  a_addr;
    logic        b_en;
    logic [4:0]  b_addr;
    logic        w_a_en;
    logic [2:0]  w_a_addr;
    logic        w_b_en;
    logic [2:0]  w_b_addr;

    logic [31:0] sel_a, sel_b;
    logic        valid_a, valid_b, collide;
    logic [7:0]  collide_cnt;

    logic [31:0] nz_sel_a, nz_sel_b;
    logic        nz_valid_a, nz_valid_b, nz_collide;
    logic [7:0]  nz_collide_cnt;

    logic [7:0]  w_sel_a, w_sel_b;
    logic        w_valid_a, w_valid_b, w_collide;
    logic [3:0]  w_collide_cnt;

    int tests_run;
    int tests_failed;

    regwr_sel_pipe dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .a_en(a_en), .a_addr(a_addr), .b_en(b_en), .b_addr(b_addr),
        .sel_a(sel_a), .sel_b(sel_b), .valid_a(valid_a), .valid_b(valid_b),
        .collide(collide), .collide_cnt(collide_cnt)
    );

    regwr_sel_pipe #(.ADDR_W(5), .ZERO_GUARD(1'b0), .CNT_W(8)) dut_nz (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .a_en(a_en), .a_addr(a_addr), .b_en(b_en), .b_addr(b_addr),
        .sel_a(nz_sel_a), .sel_b(nz_sel_b), .valid_a(nz_valid_a), .valid_b(nz_valid_b),
        .collide(nz_collide), .collide_cnt(nz_collide_cnt)
    );

    regwr_sel_pipe #(.ADDR_W(3), .ZERO_GUARD(1'b1), .CNT_W(4)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .a_en(w_a_en), .a_addr(w_a_addr), .b_en(w_b_en), .b_addr(w_b_addr),
        .sel_a(w_sel_a), .sel_b(w_sel_b), .valid_a(w_valid_a), .valid_b(w_valid_b),
        .collide(w_collide), .collide_cnt(w_collide_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        ae;
        logic [4:0]  aa;
        logic        be;
        logic [4:0]  ba;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ec;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        a_en = 1'b1; a_addr = 5'd5; b_en = 1'b0; b_addr = 5'd0;
        w_a_en = 1'b0; w_a_addr = 3'd0; w_b_en = 1'b0; w_b_addr = 3'd0;

        //         st    fl    ae    aa     be    ba     ea             eb             ec    ecnt
        vt[0]  = '{1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 5'd17, 32'h0000_0008, 32'h0002_0000, 1'b0, 8'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 5'd9,  32'h0000_0200, 32'h0000_0000, 1'b1, 8'd1};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 5'd9,  32'h0000_0200, 32'h0000_0000, 1'b1, 8'd2};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 5'd9,  32'h0000_0200, 32'h0000_0000, 1'b1, 8'd3};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0000_0000, 32'h0000_0000, 1'b0, 8'd3};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 5'd7,  32'h0000_0000, 32'h0000_0080, 1'b0, 8'd3};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd4,  32'h0000_0000, 32'h0000_0010, 1'b0, 8'd3};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 5'd12, 32'h0000_1000, 32'h0000_0000, 1'b0, 8'd3};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 5'd1,  32'h0000_1000, 32'h0000_0000, 1'b0, 8'd3};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 5'd0,  32'h0000_1000, 32'h0000_0000, 1'b0, 8'd3};
        vt[10] = '{1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 5'd5,  32'h0000_0000, 32'h0000_0000, 1'b0, 8'd3};
        vt[11] = '{1'b0, 1'b0, 1'b1, 5'd20, 1'b1, 5'd20, 32'h0010_0000, 32'h0000_0000, 1'b1, 8'd4};
        vt[12] = '{1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 5'd4,  32'h0010_0000, 32'h0000_0000, 1'b1, 8'd4};
        vt[13] = '{1'b0, 1'b1, 1'b1, 5'd20, 1'b1, 5'd20, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'd4};
        vt[14] = '{1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 5'd30, 32'h8000_0000, 32'h4000_0000, 1'b0, 8'd4};
        vt[15] = '{1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 5'd30, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'd4};

        // Reset held with a live request: nothing may appear at the outputs.
        tick();
        tick();
        chk("rst sel_a",   64'(sel_a),       64'h0);
        chk("rst sel_b",   64'(sel_b),       64'h0);
        chk("rst valid_a", 64'(valid_a),     64'h0);
        chk("rst valid_b", 64'(valid_b),     64'h0);
        chk("rst collide", 64'(collide),     64'h0);
        chk("rst cnt",     64'(collide_cnt), 64'h0);
        chk("rst w3 sel_a", 64'(w_sel_a),    64'h0);

        rst_n = 1'b1;
        tick();
        chk("post-rst sel_a",    64'(sel_a),    64'h0000_0020);
        chk("post-rst valid_a",  64'(valid_a),  64'h1);
        chk("post-rst nz sel_a", 64'(nz_sel_a), 64'h0000_0020);

        // Table-driven directed vectors on the default instance.
        for (int i = 0; i < 16; i++) begin
            stall = vt[i].st; flush = vt[i].fl;
            a_en = vt[i].ae; a_addr = vt[i].aa;
            b_en = vt[i].be; b_addr = vt[i].ba;
            tick();
            chk($sformatf("v%0d sel_a", i),   64'(sel_a),       64'(vt[i].ea));
            chk($sformatf("v%0d sel_b", i),   64'(sel_b),       64'(vt[i].eb));
            chk($sformatf("v%0d valid_a", i), 64'(valid_a),     64'(vt[i].ea != 32'h0));
            chk($sformatf("v%0d valid_b", i), 64'(valid_b),     64'(vt[i].eb != 32'h0));
            chk($sformatf("v%0d collide", i), 64'(collide),     64'(vt[i].ec));
            chk($sformatf("v%0d cnt", i),     64'(collide_cnt), 64'(vt[i].ecnt));
        end

        // Address 0 with the guard disabled decodes and collides normally.
        stall = 1'b0; flush = 1'b0;
        a_en = 1'b1; a_addr = 5'd0; b_en = 1'b1; b_addr = 5'd0;
        tick();
        chk("nz sel_a",    64'(nz_sel_a),   64'h1);
        chk("nz sel_b",    64'(nz_sel_b),   64'h0);
        chk("nz collide",  64'(nz_collide), 64'h1);
        chk("nz valid_b",  64'(nz_valid_b), 64'h0);
        chk("zg sel_a",    64'(sel_a),      64'h0);
        chk("zg collide",  64'(collide),    64'h0);
        chk("zg cnt",      64'(collide_cnt), 64'd4);

        // Saturation: 300 collisions on top of 4 previous ones.
        a_addr = 5'd9; b_addr = 5'd9;
        repeat (250) tick();
        chk("sat cnt 254", 64'(collide_cnt), 64'd254);
        repeat (50) tick();
        chk("sat cnt 255", 64'(collide_cnt), 64'd255);
        chk("sat collide", 64'(collide),     64'h1);
        chk("sat sel_a",   64'(sel_a),       64'h0000_0200);
        chk("sat sel_b",   64'(sel_b),       64'h0);

        // Exhaustive 3-bit address sweep against a reference decode.
        a_en = 1'b0; b_en = 1'b0;
        w_a_en = 1'b1; w_b_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                logic [7:0] ea, eb;
                logic       ec;
                w_a_addr = 3'(a);
                w_b_addr = 3'(b);
                ea = (a != 0) ? (8'h01 << a) : 8'h00;
                ec = (a != 0) && (a == b);
                eb = ((b != 0) && !ec) ? (8'h01 << b) : 8'h00;
                tick();
                chk($sformatf("w3 a%0d b%0d sel_a", a, b),   64'(w_sel_a),   64'(ea));
                chk($sformatf("w3 a%0d b%0d sel_b", a, b),   64'(w_sel_b),   64'(eb));
                chk($sformatf("w3 a%0d b%0d collide", a, b), 64'(w_collide), 64'(ec));
                chk($sformatf("w3 a%0d b%0d valid_b", a, b), 64'(w_valid_b), 64'(eb != 8'h00));
            end
        end
        chk("w3 cnt", 64'(w_collide_cnt), 64'd7);

        w_a_addr = 3'd7; w_b_addr = 3'd6;
        tick();
        chk("w3 a7 sel_a", 64'(w_sel_a), 64'h80);
        chk("w3 b6 sel_b", 64'(w_sel_b), 64'h40);

        // Asynchronous reset between edges clears everything at once.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async rst cnt",    64'(collide_cnt),   64'h0);
        chk("async rst w3 cnt", 64'(w_collide_cnt), 64'h0);
        chk("async rst w3 sel", 64'(w_sel_a),       64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
